// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID-to-EX offer and EX-to-MEM result bundle for the execute stage
interface ex_stage_if;
    // ID side: operation offer
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [31:0] ex_port_a;
    logic [31:0] ex_port_b;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_store_data_i;
    logic [4:0]  ex_waddr;
    logic        ex_we;
    logic [5:0]  ex_mem_flags;
    logic        ex_bad_jump_addr;
    logic        ex_bad_branch_addr;
    logic        ex_break_op;
    logic        ex_syscall_op;
    logic        flush_i;

    // MEM side: registered result
    logic        mem_ready_i;
    logic        mem_valid_o;
    logic [31:0] mem_result_o;
    logic [31:0] mem_store_data_o;
    logic [4:0]  mem_waddr_o;
    logic        mem_we_o;
    logic [5:0]  mem_mem_flags_o;
    logic [2:0]  mem_exc_cause_o;

    // Pipeline environment: drives offers, flush and MEM backpressure
    modport master (
        output ex_valid_i, ex_port_a, ex_port_b, ex_alu_op, ex_store_data_i,
               ex_waddr, ex_we, ex_mem_flags, ex_bad_jump_addr, ex_bad_branch_addr,
               ex_break_op, ex_syscall_op, flush_i, mem_ready_i,
        input  ex_ready_o, mem_valid_o, mem_result_o, mem_store_data_o,
               mem_waddr_o, mem_we_o, mem_mem_flags_o, mem_exc_cause_o
    );

    // Execute stage
    modport slave (
        input  ex_valid_i, ex_port_a, ex_port_b, ex_alu_op, ex_store_data_i,
               ex_waddr, ex_we, ex_mem_flags, ex_bad_jump_addr, ex_bad_branch_addr,
               ex_break_op, ex_syscall_op, flush_i, mem_ready_i,
        output ex_ready_o, mem_valid_o, mem_result_o, mem_store_data_o,
               mem_waddr_o, mem_we_o, mem_mem_flags_o, mem_exc_cause_o
    );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: single-cycle ALU plus bit-serial shifter with MEM handshake
module ex_stage (
    input  logic       clk,
    input  logic       rst_i,
    ex_stage_if.slave  bus
);
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_shv;
    logic [1:0]  r_shk;

    // Side information captured at accept while a multi-cycle shift runs
    logic [31:0] r_p_store;
    logic [4:0]  r_p_waddr;
    logic        r_p_we;
    logic [5:0]  r_p_flags;
    logic [2:0]  r_p_exc;

    logic        r_mem_valid;
    logic [31:0] r_mem_result;
    logic [31:0] r_mem_store;
    logic [4:0]  r_mem_waddr;
    logic        r_mem_we;
    logic [5:0]  r_mem_flags;
    logic [2:0]  r_mem_exc;

    logic        w_out_free;
    logic        w_ready;
    logic        w_accept;
    logic [4:0]  w_shamt;
    logic        w_is_shift;
    logic        w_defer;
    logic [1:0]  w_shk;
    logic [31:0] w_alu;
    logic [2:0]  w_exc;
    logic        w_we_eff;
    logic [5:0]  w_flags_eff;
    logic [31:0] w_step;

    // The output register can take new data when empty or being drained this cycle
    assign w_out_free = !r_mem_valid || bus.mem_ready_i;
    assign w_ready    = (r_state == S_IDLE) && w_out_free && !bus.flush_i;
    assign w_accept   = bus.ex_valid_i && w_ready;
    assign w_shamt    = bus.ex_port_b[4:0];
    assign w_is_shift = (bus.ex_alu_op == 4'd2) || (bus.ex_alu_op == 4'd6) ||
                        (bus.ex_alu_op == 4'd7);
    assign w_defer    = w_is_shift && (w_shamt != 5'd0);
    assign w_shk      = (bus.ex_alu_op == 4'd2) ? SH_SLL :
                        (bus.ex_alu_op == 4'd6) ? SH_SRL : SH_SRA;

    // Single-cycle ALU result; shifts here only serve the zero/immediate case
    always_comb begin
        w_alu = 32'd0;
        case (bus.ex_alu_op)
            4'd0:    w_alu = bus.ex_port_a + bus.ex_port_b;
            4'd1:    w_alu = bus.ex_port_a - bus.ex_port_b;
            4'd2:    w_alu = bus.ex_port_a << w_shamt;
            4'd3:    w_alu = {31'd0, $signed(bus.ex_port_a) < $signed(bus.ex_port_b)};
            4'd4:    w_alu = {31'd0, bus.ex_port_a < bus.ex_port_b};
            4'd5:    w_alu = bus.ex_port_a ^ bus.ex_port_b;
            4'd6:    w_alu = bus.ex_port_a >> w_shamt;
            4'd7:    w_alu = $unsigned($signed(bus.ex_port_a) >>> w_shamt);
            4'd8:    w_alu = bus.ex_port_a | bus.ex_port_b;
            4'd9:    w_alu = bus.ex_port_a & bus.ex_port_b;
            default: w_alu = 32'd0;
        endcase
    end

    // Exception cause with fixed priority jump > branch > break > syscall
    always_comb begin
        w_exc = 3'd0;
        if (bus.ex_bad_jump_addr)        w_exc = 3'd1;
        else if (bus.ex_bad_branch_addr) w_exc = 3'd2;
        else if (bus.ex_break_op)        w_exc = 3'd3;
        else if (bus.ex_syscall_op)      w_exc = 3'd4;
    end

    assign w_we_eff    = bus.ex_we && (bus.ex_waddr != 5'd0) && (w_exc == 3'd0);
    assign w_flags_eff = (w_exc != 3'd0) ? 6'd0 : bus.ex_mem_flags;

    // One-bit shift step; arithmetic right shift replicates the sign bit
    always_comb begin
        w_step = r_shv;
        case (r_shk)
            SH_SLL:  w_step = {r_shv[30:0], 1'b0};
            SH_SRL:  w_step = {1'b0, r_shv[31:1]};
            default: w_step = {r_shv[31], r_shv[31:1]};
        endcase
    end

    // Stage FSM: accepts, runs the serial shifter and owns the output register
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= 5'd0;
            r_shv        <= 32'd0;
            r_shk        <= SH_SLL;
            r_p_store    <= 32'd0;
            r_p_waddr    <= 5'd0;
            r_p_we       <= 1'b0;
            r_p_flags    <= 6'd0;
            r_p_exc      <= 3'd0;
            r_mem_valid  <= 1'b0;
            r_mem_result <= 32'd0;
            r_mem_store  <= 32'd0;
            r_mem_waddr  <= 5'd0;
            r_mem_we     <= 1'b0;
            r_mem_flags  <= 6'd0;
            r_mem_exc    <= 3'd0;
        end else if (bus.flush_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_mem_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_defer) begin
                        r_state     <= S_SHIFT;
                        r_cnt       <= w_shamt;
                        r_shv       <= bus.ex_port_a;
                        r_shk       <= w_shk;
                        r_p_store   <= bus.ex_store_data_i;
                        r_p_waddr   <= bus.ex_waddr;
                        r_p_we      <= w_we_eff;
                        r_p_flags   <= w_flags_eff;
                        r_p_exc     <= w_exc;
                        r_mem_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_mem_valid  <= 1'b1;
                        r_mem_result <= w_alu;
                        r_mem_store  <= bus.ex_store_data_i;
                        r_mem_waddr  <= bus.ex_waddr;
                        r_mem_we     <= w_we_eff;
                        r_mem_flags  <= w_flags_eff;
                        r_mem_exc    <= w_exc;
                    end else if (bus.mem_ready_i) begin
                        r_mem_valid <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == 5'd1) begin
                        // Final step lands straight in the output register, waiting if MEM stalls
                        if (w_out_free) begin
                            r_state      <= S_IDLE;
                            r_cnt        <= 5'd0;
                            r_shv        <= w_step;
                            r_mem_valid  <= 1'b1;
                            r_mem_result <= w_step;
                            r_mem_store  <= r_p_store;
                            r_mem_waddr  <= r_p_waddr;
                            r_mem_we     <= r_p_we;
                            r_mem_flags  <= r_p_flags;
                            r_mem_exc    <= r_p_exc;
                        end
                    end else begin
                        r_shv <= w_step;
                        r_cnt <= r_cnt - 5'd1;
                        if (bus.mem_ready_i) begin
                            r_mem_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 5'd0;
                end
            endcase
        end
    end

    assign bus.ex_ready_o       = w_ready;
    assign bus.mem_valid_o      = r_mem_valid;
    assign bus.mem_result_o     = r_mem_result;
    assign bus.mem_store_data_o = r_mem_store;
    assign bus.mem_waddr_o      = r_mem_waddr;
    assign bus.mem_we_o         = r_mem_we;
    assign bus.mem_mem_flags_o  = r_mem_flags;
    assign bus.mem_exc_cause_o  = r_mem_exc;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized and directed self-checking bench for ex_stage
module tb_ex_stage;
    logic clk;
    logic rst_i;

    ex_stage_if bus ();

    ex_stage u_dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [3:0]  op;
        logic [4:0]  wa;
        logic        we;
        logic [5:0]  fl;
        logic        bj;
        logic        bb;
        logic        brk;
        logic        sys;
    } op_t;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  wa;
        logic        we;
        logic [5:0]  fl;
        logic [2:0]  exc;
    } out_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what MEM should see, and how many shift cycles remain
    logic m_valid;
    out_t m_out;
    int   m_pend;
    out_t m_pend_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned n;
        n = int'(b[4:0]);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << n;
            4'd3: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> n;
            4'd7: return a[31] ? ~((~a) >> n) : (a >> n);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic out_t expect_of(input op_t o);
        out_t r;
        r.res = ref_alu(o.op, o.a, o.b);
        r.sd  = o.sd;
        r.wa  = o.wa;
        if (o.bj)       r.exc = 3'd1;
        else if (o.bb)  r.exc = 3'd2;
        else if (o.brk) r.exc = 3'd3;
        else if (o.sys) r.exc = 3'd4;
        else            r.exc = 3'd0;
        r.we = o.we && (o.wa != 5'd0) && (r.exc == 3'd0);
        r.fl = (r.exc != 3'd0) ? 6'd0 : o.fl;
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a   = $urandom;
        o.b   = $urandom;
        o.sd  = $urandom;
        o.op  = 4'($urandom_range(15));
        o.wa  = 5'($urandom_range(31));
        o.we  = 1'($urandom_range(1));
        o.fl  = 6'($urandom_range(63));
        o.bj  = ($urandom_range(7) == 0);
        o.bb  = ($urandom_range(7) == 0);
        o.brk = ($urandom_range(7) == 0);
        o.sys = ($urandom_range(7) == 0);
        return o;
    endfunction

    function automatic op_t mk_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] wa, input logic we);
        op_t o;
        o     = '0;
        o.op  = op;
        o.a   = a;
        o.b   = b;
        o.wa  = wa;
        o.we  = we;
        o.sd  = 32'h1234_5678;
        o.fl  = 6'h2a;
        return o;
    endfunction

    // One cycle: drive inputs, compare at negedge, advance model, wait for the edge
    task automatic step(input op_t o, input logic v, input logic mr, input logic fl);
        logic exp_ready;
        logic free;
        logic acc;
        int   n;
        bus.ex_valid_i         = v;
        bus.ex_port_a          = o.a;
        bus.ex_port_b          = o.b;
        bus.ex_alu_op          = o.op;
        bus.ex_store_data_i    = o.sd;
        bus.ex_waddr           = o.wa;
        bus.ex_we              = o.we;
        bus.ex_mem_flags       = o.fl;
        bus.ex_bad_jump_addr   = o.bj;
        bus.ex_bad_branch_addr = o.bb;
        bus.ex_break_op        = o.brk;
        bus.ex_syscall_op      = o.sys;
        bus.mem_ready_i        = mr;
        bus.flush_i            = fl;
        @(negedge clk);
        free      = !m_valid || mr;
        exp_ready = (m_pend == 0) && free && !fl;
        check("ready", 32'(bus.ex_ready_o), 32'(exp_ready));
        check("valid", 32'(bus.mem_valid_o), 32'(m_valid));
        if (m_valid) begin
            check("result", bus.mem_result_o, m_out.res);
            check("store", bus.mem_store_data_o, m_out.sd);
            check("waddr", 32'(bus.mem_waddr_o), 32'(m_out.wa));
            check("we", 32'(bus.mem_we_o), 32'(m_out.we));
            check("flags", 32'(bus.mem_mem_flags_o), 32'(m_out.fl));
            check("exc", 32'(bus.mem_exc_cause_o), 32'(m_out.exc));
        end
        if (fl) begin
            m_valid = 1'b0;
            m_pend  = 0;
        end else begin
            acc = v && exp_ready;
            n   = int'(o.b[4:0]);
            if (acc && (o.op == 4'd2 || o.op == 4'd6 || o.op == 4'd7) && n != 0) begin
                m_pend     = n;
                m_pend_out = expect_of(o);
                m_valid    = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1;
                m_out   = expect_of(o);
            end else if (m_pend == 1 && free) begin
                m_pend  = 0;
                m_valid = 1'b1;
                m_out   = m_pend_out;
            end else begin
                if (m_pend > 1) m_pend = m_pend - 1;
                if (m_valid && mr) m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step('0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.mem_valid_o), 32'd0);
        check({tag, "_result"}, bus.mem_result_o, 32'd0);
        check({tag, "_store"}, bus.mem_store_data_o, 32'd0);
        check({tag, "_waddr"}, 32'(bus.mem_waddr_o), 32'd0);
        check({tag, "_we"}, 32'(bus.mem_we_o), 32'd0);
        check({tag, "_flags"}, 32'(bus.mem_mem_flags_o), 32'd0);
        check({tag, "_exc"}, 32'(bus.mem_exc_cause_o), 32'd0);
    endtask

    initial begin
        op_t o;
        m_valid    = 1'b0;
        m_pend     = 0;
        m_out      = '0;
        m_pend_out = '0;
        rst_i      = 1'b0;
        bus.ex_valid_i = 1'b0; bus.ex_port_a = '0; bus.ex_port_b = '0; bus.ex_alu_op = '0;
        bus.ex_store_data_i = '0; bus.ex_waddr = '0; bus.ex_we = 1'b0; bus.ex_mem_flags = '0;
        bus.ex_bad_jump_addr = 1'b0; bus.ex_bad_branch_addr = 1'b0; bus.ex_break_op = 1'b0;
        bus.ex_syscall_op = 1'b0; bus.flush_i = 1'b0; bus.mem_ready_i = 1'b0;

        // Reset state before any clock edge, then release just after an edge
        #3;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b1;

        // ADD wraps modulo 2^32, one-cycle latency
        step(mk_op(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1), 1'b1, 1'b1, 1'b0);
        check("add_valid", 32'(bus.mem_valid_o), 32'd1);
        check("add_result", bus.mem_result_o, 32'd0);
        check("add_we", 32'(bus.mem_we_o), 32'd1);
        check("add_waddr", 32'(bus.mem_waddr_o), 32'd5);
        idle(1);

        // SRA by 4: busy for 4 cycles, result on the 5th edge
        step(mk_op(4'd7, 32'h8000_0000, 32'h0000_0104, 5'd3, 1'b1), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("sra_busy", 32'(bus.ex_ready_o), 32'd0);
            step('0, 1'b0, 1'b1, 1'b0);
        end
        check("sra_valid", 32'(bus.mem_valid_o), 32'd1);
        check("sra_result", bus.mem_result_o, 32'hF800_0000);
        idle(1);

        // Backpressure: output held three cycles while a new op waits
        step(mk_op(4'd5, 32'hA5A5_0000, 32'h0000_5A5A, 5'd9, 1'b1), 1'b1, 1'b1, 1'b0);
        o = mk_op(4'd1, 32'd10, 32'd3, 5'd4, 1'b1);
        for (int i = 0; i < 3; i++) step(o, 1'b1, 1'b0, 1'b0);
        check("hold_result", bus.mem_result_o, 32'hA5A5_5A5A);
        step(o, 1'b1, 1'b1, 1'b0);
        check("hold_next", bus.mem_result_o, 32'd7);
        idle(1);

        // Flush during a 20-bit shift with a new op offered
        step(mk_op(4'd6, 32'hFFFF_0000, 32'd20, 5'd2, 1'b1), 1'b1, 1'b1, 1'b0);
        idle(3);
        step(mk_op(4'd0, 32'd1, 32'd1, 5'd6, 1'b1), 1'b1, 1'b1, 1'b1);
        check("flush_valid", 32'(bus.mem_valid_o), 32'd0);
        idle(22);

        // Exception priority: branch beats syscall, write and flags suppressed
        o     = mk_op(4'd0, 32'd1, 32'd2, 5'd7, 1'b1);
        o.fl  = 6'h3f;
        o.bb  = 1'b1;
        o.sys = 1'b1;
        step(o, 1'b1, 1'b1, 1'b0);
        check("exc_cause", 32'(bus.mem_exc_cause_o), 32'd2);
        check("exc_we", 32'(bus.mem_we_o), 32'd0);
        check("exc_flags", 32'(bus.mem_mem_flags_o), 32'd0);
        idle(1);

        // Asynchronous reset mid-shift with non-zero data in the output register
        step(mk_op(4'd8, 32'h0F0F_0000, 32'h0000_00F0, 5'd11, 1'b1), 1'b1, 1'b1, 1'b0);
        step(mk_op(4'd2, 32'h0000_0001, 32'd10, 5'd12, 1'b1), 1'b1, 1'b1, 1'b0);
        idle(2);
        #2 rst_i = 1'b0;
        #1;
        check_all_zero("async_rst");
        m_valid = 1'b0;
        m_pend  = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b1;
        step(mk_op(4'd9, 32'hFFFF_00FF, 32'h0F0F_0F0F, 5'd1, 1'b1), 1'b1, 1'b1, 1'b0);
        check("post_rst_valid", 32'(bus.mem_valid_o), 32'd1);

        // Randomized traffic with backpressure and occasional flush
        for (int i = 0; i < 1500; i++) begin
            step(rand_op(), ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                 ($urandom_range(39) == 0));
        end

        // Back-to-back single-cycle ops at full rate
        for (int i = 0; i < 20; i++) begin
            o    = rand_op();
            o.op = 4'd0;
            step(o, 1'b1, 1'b1, 1'b0);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
